uart_tx_dev: RTL and testbench

- Memory-mapped UART transmitter. Attaches as a new device slot on the simple-system bus, alongside ram, simulator_ctrl and timer, in the 1 kB window at 0x40000.
- Software writes bytes into a TX FIFO.
- A baud-rate generator and a shift FSM serialise each byte as an 8N1 frame on tx_o.
- An optional level interrupt fires when transmission has drained.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx_dev.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_dev.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter device: register offsets,
// STATUS bit positions and the transmit FSM state type.
package uart_pkg;

    localparam logic [9:0] OffTxData  = 10'h000;
    localparam logic [9:0] OffStatus  = 10'h004;
    localparam logic [9:0] OffBaudDiv = 10'h008;
    localparam logic [9:0] OffCtrl    = 10'h00C;

    localparam int StatFullBit  = 0;
    localparam int StatEmptyBit = 1;
    localparam int StatBusyBit  = 2;
    localparam int StatOvfBit   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with a power-of-two depth; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);
    localparam int AddrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [AddrW:0]   level_q;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AddrW + 1)'(Depth));
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally in AddrW bits because Depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: bus register file, baud counter and
// shift FSM draining a TX FIFO onto tx_o.
module uart_tx_dev
    import uart_pkg::*;
#(
    parameter int          DataWidth      = 32,
    parameter int          AddressWidth   = 32,
    parameter int          FifoDepth      = 16,
    parameter logic [15:0] DefaultBaudDiv = 16'd87
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dev_req_i,
    input  logic                    dev_we_i,
    input  logic [3:0]              dev_be_i,
    input  logic [AddressWidth-1:0] dev_addr_i,
    input  logic [DataWidth-1:0]    dev_wdata_i,
    output logic                    dev_rvalid_o,
    output logic [DataWidth-1:0]    dev_rdata_o,
    output logic                    dev_err_o,
    output logic                    tx_o,
    output logic                    tx_intr_o
);
    localparam int LevelW = $clog2(FifoDepth) + 1;

    logic [9:0]           offset;
    logic                 addr_ok, bus_wr, bus_rd;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]           fifo_rdata;
    logic [LevelW-1:0]    fifo_level;

    logic                 rvalid_q, err_q, ovf_q, intr_q;
    logic [DataWidth-1:0] rdata_q, read_d;
    logic [15:0]          baud_q;
    logic [1:0]           ctrl_q;

    tx_state_e            state_q, state_d;
    logic [15:0]          cnt_q, reload;
    logic [2:0]           bit_q;
    logic [7:0]           shift_q;
    logic                 bit_end, can_start, cnt_load, tx_d;

    logic                 unused_bits;
    assign unused_bits = ^{dev_addr_i[AddressWidth-1:10], dev_wdata_i[DataWidth-1:16], dev_be_i[3:2]};

    assign offset    = dev_addr_i[9:0];
    assign addr_ok   = offset inside {OffTxData, OffStatus, OffBaudDiv, OffCtrl};
    assign bus_wr    = dev_req_i & dev_we_i;
    assign bus_rd    = dev_req_i & ~dev_we_i;
    assign fifo_push = bus_wr & (offset == OffTxData) & dev_be_i[0];

    uart_tx_fifo #(
        .Width (8),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i (dev_wdata_i[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        read_d = '0;
        case (offset)
            OffStatus: begin
                read_d[StatFullBit]  = fifo_full;
                read_d[StatEmptyBit] = fifo_empty;
                read_d[StatBusyBit]  = (state_q != IDLE);
                read_d[StatOvfBit]   = ovf_q;
                read_d[15:8]         = 8'(fifo_level);
            end
            OffBaudDiv: read_d[15:0] = baud_q;
            OffCtrl:    read_d[1:0]  = ctrl_q;
            default:    read_d       = '0;
        endcase
    end

    // A push that hits a full FIFO is only lost when no pop frees a slot that cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            baud_q   <= DefaultBaudDiv;
            ctrl_q   <= 2'b00;
            ovf_q    <= 1'b0;
            intr_q   <= 1'b0;
        end else begin
            rvalid_q <= dev_req_i;
            err_q    <= dev_req_i & ~addr_ok;
            rdata_q  <= (bus_rd && addr_ok) ? read_d : '0;
            if (bus_wr && offset == OffBaudDiv) begin
                if (dev_be_i[0]) baud_q[7:0]  <= dev_wdata_i[7:0];
                if (dev_be_i[1]) baud_q[15:8] <= dev_wdata_i[15:8];
            end
            if (bus_wr && offset == OffCtrl) begin
                ctrl_q <= dev_wdata_i[1:0];
            end
            if (fifo_push && fifo_full && !fifo_pop) begin
                ovf_q <= 1'b1;
            end else if (bus_wr && offset == OffStatus && dev_wdata_i[StatOvfBit]) begin
                ovf_q <= 1'b0;
            end
            intr_q <= ctrl_q[1] & fifo_empty & (state_q == IDLE);
        end
    end

    assign bit_end   = (cnt_q == 16'd0);
    assign can_start = ctrl_q[0] & ~fifo_empty;
    assign reload    = (baud_q == 16'd0) ? 16'd0 : baud_q - 16'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (can_start) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && bit_q == 3'd7) state_d = STOP;
            STOP:    if (bit_end) state_d = can_start ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The STOP-to-START pop gives back-to-back frames with no idle cycle.
    always_comb begin
        fifo_pop = 1'b0;
        cnt_load = 1'b0;
        tx_d     = 1'b1;
        case (state_q)
            IDLE: begin
                fifo_pop = can_start;
                cnt_load = can_start;
            end
            START: begin
                tx_d     = 1'b0;
                cnt_load = bit_end;
            end
            DATA: begin
                tx_d     = shift_q[0];
                cnt_load = bit_end;
            end
            STOP: begin
                fifo_pop = bit_end & can_start;
                cnt_load = bit_end & can_start;
            end
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            if (cnt_load) begin
                cnt_q <= reload;
            end else if (!bit_end) begin
                cnt_q <= cnt_q - 16'd1;
            end
            if (fifo_pop) begin
                shift_q <= fifo_rdata;
            end else if (state_q == DATA && bit_end) begin
                shift_q <= {1'b0, shift_q[7:1]};
            end
            if (state_q == START) begin
                bit_q <= 3'd0;
            end else if (state_q == DATA && bit_end) begin
                bit_q <= bit_q + 3'd1;
            end
        end
    end

    assign dev_rvalid_o = rvalid_q;
    assign dev_rdata_o  = rdata_q;
    assign dev_err_o    = err_q;
    assign tx_o         = tx_d;
    assign tx_intr_o    = intr_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Randomised bench for uart_tx_dev: a frame-level model predicts every output
// each cycle, and hand-computed frames and register values pin the model.
module tb_uart_tx_dev;

    localparam int Depth = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        dev_req_i = 1'b0;
    logic        dev_we_i = 1'b0;
    logic [3:0]  dev_be_i = 4'h0;
    logic [31:0] dev_addr_i = 32'h0;
    logic [31:0] dev_wdata_i = 32'h0;
    logic        dev_rvalid_o, dev_err_o, tx_o, tx_intr_o;
    logic [31:0] dev_rdata_o;

    int testsRun = 0;
    int testsFailed = 0;
    bit checkEn = 1'b0;

    logic [7:0]  mq[$];
    logic [15:0] mBaud;
    logic [1:0]  mCtrl;
    bit          mOvf, mBusy;
    int          mBitIdx, mBitLeft;
    logic [7:0]  mCur;
    logic        expRvalid, expErr, expTx, expIntr;
    logic [31:0] expRdata;

    logic txLog[$];

    int f55[$] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int fA53C[$] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
    int f96[$] = '{0, 0, 1, 1, 0, 1, 0, 0, 1, 1};

    uart_tx_dev #(
        .DataWidth      (32),
        .AddressWidth   (32),
        .FifoDepth      (Depth),
        .DefaultBaudDiv (16'd87)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .dev_req_i    (dev_req_i),
        .dev_we_i     (dev_we_i),
        .dev_be_i     (dev_be_i),
        .dev_addr_i   (dev_addr_i),
        .dev_wdata_i  (dev_wdata_i),
        .dev_rvalid_o (dev_rvalid_o),
        .dev_rdata_o  (dev_rdata_o),
        .dev_err_o    (dev_err_o),
        .tx_o         (tx_o),
        .tx_intr_o    (tx_intr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Model: a frame is ten bit slots, each max(BAUD_DIV,1) cycles long.
    task automatic modelReset();
        mq.delete();
        mBaud = 16'd87;
        mCtrl = 2'b00;
        mOvf = 1'b0;
        mBusy = 1'b0;
        mBitIdx = 0;
        mBitLeft = 0;
        mCur = 8'h00;
        expRvalid = 1'b0;
        expErr = 1'b0;
        expRdata = 32'h0;
        expTx = 1'b1;
        expIntr = 1'b0;
    endtask

    function automatic logic [31:0] modelRead(input logic [9:0] off);
        logic [31:0] v;
        v = 32'h0;
        case (off)
            10'h004: v = {16'h0, 8'(mq.size()), 4'h0, mOvf, mBusy, (mq.size() == 0), (mq.size() == Depth)};
            10'h008: v = {16'h0, mBaud};
            10'h00C: v = {30'h0, mCtrl};
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    function automatic logic frameBit();
        if (mBitIdx == 0) return 1'b0;
        if (mBitIdx == 9) return 1'b1;
        return mCur[mBitIdx - 1];
    endfunction

    task automatic modelStep();
        logic [9:0] off;
        logic ok, wr, rd;
        int div1;
        bit popNow;
        off = dev_addr_i[9:0];
        ok = (off == 10'h000) || (off == 10'h004) || (off == 10'h008) || (off == 10'h00C);
        wr = dev_req_i && dev_we_i;
        rd = dev_req_i && !dev_we_i;
        expRvalid = dev_req_i;
        expErr = dev_req_i && !ok;
        expRdata = (rd && ok) ? modelRead(off) : 32'h0;
        expIntr = mCtrl[1] && (mq.size() == 0) && !mBusy;
        div1 = (mBaud == 16'd0) ? 1 : int'(mBaud);
        popNow = 1'b0;
        if (!mBusy) begin
            popNow = mCtrl[0] && (mq.size() > 0);
        end else begin
            mBitLeft--;
            if (mBitLeft == 0) begin
                if (mBitIdx < 9) begin
                    mBitIdx++;
                    mBitLeft = div1;
                end else if (mCtrl[0] && mq.size() > 0) begin
                    popNow = 1'b1;
                end else begin
                    mBusy = 1'b0;
                end
            end
        end
        if (popNow) begin
            mCur = mq.pop_front();
            mBusy = 1'b1;
            mBitIdx = 0;
            mBitLeft = div1;
        end
        if (wr && off == 10'h000 && dev_be_i[0]) begin
            if (mq.size() < Depth) mq.push_back(dev_wdata_i[7:0]);
            else mOvf = 1'b1;
        end
        if (wr && off == 10'h004 && dev_wdata_i[3]) mOvf = 1'b0;
        if (wr && off == 10'h008) begin
            if (dev_be_i[0]) mBaud[7:0] = dev_wdata_i[7:0];
            if (dev_be_i[1]) mBaud[15:8] = dev_wdata_i[15:8];
        end
        if (wr && off == 10'h00C) mCtrl = dev_wdata_i[1:0];
        expTx = mBusy ? frameBit() : 1'b1;
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) modelReset();
            else modelStep();
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (checkEn) begin
                checkOutput("tx_o", 32'(tx_o), 32'(expTx));
                checkOutput("tx_intr_o", 32'(tx_intr_o), 32'(expIntr));
                checkOutput("dev_rvalid_o", 32'(dev_rvalid_o), 32'(expRvalid));
                checkOutput("dev_err_o", 32'(dev_err_o), 32'(expErr));
                if (expRvalid) checkOutput("dev_rdata_o", dev_rdata_o, expRdata);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic req, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk_i);
        dev_req_i = req;
        dev_we_i = we;
        dev_be_i = be;
        dev_addr_i = addr;
        dev_wdata_i = wdata;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h0004_0000 | addr, data);
        idleCycles(1);
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h0004_0000 | addr, 32'h0);
        idleCycles(1);
        data = dev_rdata_o;
    endtask

    task automatic captureTx(input int n);
        txLog.delete();
        repeat (n) begin
            idleCycles(1);
            txLog.push_back(tx_o);
        end
    endtask

    task automatic checkWave(input string name, input int bits[$], input int div);
        int start;
        int idx;
        logic actual;
        start = -1;
        foreach (txLog[i]) if (start < 0 && txLog[i] == 1'b0) start = i;
        checkOutput({name, " start bit seen"}, 32'(start >= 0), 32'd1);
        if (start < 0) return;
        for (int b = 0; b < bits.size(); b++) begin
            actual = 1'(bits[b]);
            for (int c = 0; c < div; c++) begin
                idx = start + b * div + c;
                if (idx < txLog.size() && txLog[idx] !== 1'(bits[b])) actual = txLog[idx];
            end
            checkOutput($sformatf("%s slot %0d", name, b), 32'(actual), 32'(bits[b]));
        end
        idx = start + bits.size() * div;
        if (idx < txLog.size()) checkOutput({name, " line idle after frame"}, 32'(txLog[idx]), 32'd1);
    endtask

    task automatic waitDrain(input int limit);
        int n;
        logic [31:0] rd;
        n = 0;
        while ((mq.size() != 0 || mBusy) && n < limit) begin
            idleCycles(1);
            n++;
        end
        checkOutput("drain within bound", 32'(n < limit), 32'd1);
        busWrite(32'h4, 32'h8);
        busRead(32'h4, rd);
        checkOutput("STATUS after drain", rd, 32'h0000_0002);
    endtask

    initial begin
        logic [31:0] rd;
        logic [9:0] off;
        logic [31:0] wd;
        int sel;

        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b1;
        checkEn = 1'b1;
        checkOutput("reset tx_o", 32'(tx_o), 32'd1);
        checkOutput("reset tx_intr_o", 32'(tx_intr_o), 32'd0);
        busRead(32'h4, rd);
        checkOutput("reset STATUS", rd, 32'h0000_0002);
        busRead(32'h8, rd);
        checkOutput("reset BAUD_DIV", rd, 32'd87);

        busWrite(32'h8, 32'd4);
        busWrite(32'hC, 32'd1);
        busWrite(32'h0, 32'h55);
        captureTx(48);
        checkWave("frame 0x55 div4", f55, 4);
        busRead(32'h4, rd);
        checkOutput("STATUS after 0x55", rd, 32'h0000_0002);

        busWrite(32'hC, 32'd0);
        busWrite(32'h0, 32'hA5);
        busWrite(32'h0, 32'h3C);
        busWrite(32'h8, 32'd2);
        busWrite(32'hC, 32'd1);
        captureTx(48);
        checkWave("frames 0xA5,0x3C div2", fA53C, 2);
        busWrite(32'hC, 32'd3);
        idleCycles(1);
        checkOutput("irq after drain", 32'(tx_intr_o), 32'd1);

        busWrite(32'hC, 32'd0);
        for (int i = 0; i < 17; i++) busWrite(32'h0, $urandom & 32'hFF);
        busRead(32'h4, rd);
        checkOutput("STATUS after 17 pushes", rd, 32'h0000_1009);
        busWrite(32'h4, 32'h8);
        busRead(32'h4, rd);
        checkOutput("STATUS after OVF clear", rd, 32'h0000_1001);

        applyStimulus(1'b1, 1'b0, 4'hF, 32'h0004_0010, 32'h0);
        idleCycles(1);
        checkOutput("bad offset rvalid", 32'(dev_rvalid_o), 32'd1);
        checkOutput("bad offset err", 32'(dev_err_o), 32'd1);
        checkOutput("bad offset rdata", dev_rdata_o, 32'h0);
        busRead(32'h8, rd);
        checkOutput("BAUD_DIV after bad access", rd, 32'd2);
        busRead(32'h4, rd);
        checkOutput("STATUS after bad access", rd, 32'h0000_1001);

        busWrite(32'h8, 32'd0);
        busWrite(32'hC, 32'd1);
        waitDrain(400);
        busWrite(32'h0, 32'h96);
        captureTx(14);
        checkWave("frame 0x96 div0", f96, 1);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 35) begin
                sel = $urandom_range(0, 7);
                wd = $urandom;
                case (sel)
                    0, 1, 2: off = 10'h000;
                    3: off = 10'h004;
                    4: begin
                        off = 10'h008;
                        wd = $urandom_range(0, 5);
                    end
                    5: off = 10'h00C;
                    default: begin
                        off = 10'($urandom);
                        if (off inside {10'h000, 10'h004, 10'h008, 10'h00C}) off = 10'h010;
                    end
                endcase
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                              ($urandom & 32'hFFFF_FC00) | 32'(off), wd);
            end else begin
                idleCycles(1);
            end
        end

        busWrite(32'h8, 32'd4);
        busWrite(32'hC, 32'd1);
        waitDrain(3000);
        busWrite(32'h0, 32'hC3);
        idleCycles(14);
        checkOutput("tx in DATA bit2 of 0xC3", 32'(tx_o), 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("tx_o high during reset", 32'(tx_o), 32'd1);
        repeat (2) @(negedge clk_i);
        #2 rst_ni = 1'b1;
        busRead(32'h4, rd);
        checkOutput("STATUS after mid-frame reset", rd, 32'h0000_0002);
        busRead(32'hC, rd);
        checkOutput("CTRL after mid-frame reset", rd, 32'h0);

        idleCycles(2);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
